// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: IDLE -> SETUP -> ACCESS per transfer.
// Optional watchdog abort on stuck pready enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t              state_r, state_next_s;
  logic                rr_r, rr_s;
  logic                gnt_r, gnt_s;
  logic                grant_idx_s;
  logic                timeout_s;
  logic [1:0]          ack_s, done_s;
  logic [DATA_W-1:0]   rdata_s, pwdata_s;
  logic [ADDR_W-1:0]   paddr_s;
  logic                err_s, psel_s, penable_s, pwrite_s;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] cnt_r;

  // Wait-state counter: cleared while in SETUP, counts stalled ACCESS cycles
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_r <= 8'd0;
    end else if (state_r == SETUP) begin
      cnt_r <= 8'd0;
    end else if (state_r == ACCESS && !pready) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign timeout_s = (cnt_r == TIMEOUT_C) && !pready;
`else
  assign timeout_s = 1'b0;
`endif

  // Both valid -> follow the pointer; otherwise the single valid requester
  assign grant_idx_s = (req_valid == 2'b11) ? rr_r : req_valid[1];

  // State and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r   <= IDLE;
      rr_r      <= 1'b0;
      gnt_r     <= 1'b0;
      req_ack   <= 2'b00;
      req_done  <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state_r   <= state_next_s;
      rr_r      <= rr_s;
      gnt_r     <= gnt_s;
      req_ack   <= ack_s;
      req_done  <= done_s;
      rsp_rdata <= rdata_s;
      rsp_err   <= err_s;
      psel      <= psel_s;
      penable   <= penable_s;
      pwrite    <= pwrite_s;
      paddr     <= paddr_s;
      pwdata    <= pwdata_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) state_next_s = SETUP;
        else            state_next_s = IDLE;
      end
      SETUP:  state_next_s = ACCESS;
      ACCESS: begin
        if (pready || timeout_s) state_next_s = IDLE;
        else                     state_next_s = ACCESS;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    rr_s      = rr_r;
    gnt_s     = gnt_r;
    ack_s     = 2'b00;
    done_s    = 2'b00;
    rdata_s   = rsp_rdata;
    err_s     = rsp_err;
    psel_s    = 1'b0;
    penable_s = 1'b0;
    pwrite_s  = pwrite;
    paddr_s   = paddr;
    pwdata_s  = pwdata;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          gnt_s         = grant_idx_s;
          rr_s          = ~grant_idx_s;
          ack_s[grant_idx_s] = 1'b1;
          psel_s        = 1'b1;
          pwrite_s      = req_write[grant_idx_s];
          paddr_s       = grant_idx_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_s      = grant_idx_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end else begin
          psel_s = 1'b0;
        end
      end
      SETUP: begin
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          done_s[gnt_r] = 1'b1;
          err_s         = 1'b0;
          if (!pwrite) rdata_s = prdata;
          else         rdata_s = rsp_rdata;
        end else if (timeout_s) begin
          done_s[gnt_r] = 1'b1;
          err_s         = 1'b1;
        end else begin
          psel_s    = 1'b1;
          penable_s = 1'b1;
        end
      end
      default: begin
        psel_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small wait-state APB slave model.
module tb_apb_master_arbiter;
  logic       pclk = 1'b0;
  logic       preset;
  logic [1:0] req_valid, req_write, req_ack, req_done;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0] rsp_rdata, pwdata, prdata;
  logic       rsp_err, psel, penable, pwrite, pready;
  logic [3:0] paddr;

  logic [7:0] mem [16];
  logic [7:0] ws_cnt;
  logic [7:0] wait_cfg;
  logic       stuck;
  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  assign pready = stuck ? 1'b0 : (ws_cnt >= wait_cfg);
  assign prdata = mem[paddr];

  always @(posedge pclk) begin
    if (psel && penable && !pready) ws_cnt <= ws_cnt + 8'd1;
    else                            ws_cnt <= 8'd0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    preset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = 8'h00;
    req_wdata = 16'h0000; wait_cfg = 8'd0; stuck = 1'b0; ws_cnt = 8'd0;
    step(); step();
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_ack_done", 32'({req_ack, req_done}), 32'd0);
    chk("rst_paddr_pwdata", 32'({paddr, pwdata, rsp_rdata}), 32'd0);
    chk("rst_err_write", 32'({rsp_err, pwrite}), 32'd0);
    preset = 1'b0;
    step();

    // req0 writes A5 to addr 3, no wait states
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h03; req_wdata = 16'h00A5;
    step();
    chk("w_ack", 32'(req_ack), 32'd1);
    chk("w_setup", 32'({psel, penable}), 32'b10);
    chk("w_paddr", 32'(paddr), 32'd3);
    chk("w_pwdata", 32'({pwrite, pwdata}), 32'h1A5);
    req_valid = 2'b00;
    step();
    chk("w_access", 32'({psel, penable, req_ack, req_done}), 32'b110000);
    step();
    chk("w_done", 32'(req_done), 32'd1);
    chk("w_idle", 32'({psel, penable, rsp_err}), 32'd0);
    chk("w_mem3", 32'(mem[3]), 32'hA5);
    step();
    chk("w_done_pulse", 32'(req_done), 32'd0);

    // req1 reads addr 3 with two wait states
    wait_cfg = 8'd2;
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h30;
    step();
    chk("r_ack", 32'(req_ack), 32'd2);
    req_valid = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("r_wait_c%0d", c), 32'({psel, penable, paddr, req_done}), {26'd0, 2'b11, 4'd3, 2'b00});
    end
    step();
    chk("r_done", 32'(req_done), 32'd2);
    chk("r_rdata", 32'(rsp_rdata), 32'hA5);
    chk("r_err", 32'(rsp_err), 32'd0);
    step();

    // both requesters valid continuously: grants alternate 0,1,0,1
    wait_cfg = 8'd0;
    req_valid = 2'b11; req_write = 2'b11; req_addr = 8'h65; req_wdata = 16'h2211;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_ack%0d", i), 32'(req_ack), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr_paddr%0d", i), 32'(paddr), (i % 2 == 0) ? 32'd5 : 32'd6);
      chk($sformatf("rr_ptr%0d", i), 32'(dut.rr_r), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 3) req_valid = 2'b00;
      step(); step();
      chk($sformatf("rr_done%0d", i), 32'(req_done), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    chk("rr_mem5", 32'(mem[5]), 32'h11);
    chk("rr_mem6", 32'(mem[6]), 32'h22);
    step();

`ifdef APB_TIMEOUT_EN
    // pready stuck low: abort with rsp_err at N+7
    stuck = 1'b1;
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h03;
    step();
    req_valid = 2'b00;
    for (int c = 2; c <= 6; c++) begin
      step();
      chk($sformatf("to_wait_c%0d", c), 32'({psel, req_done}), 32'b100);
    end
    step();
    chk("to_done", 32'({req_done, rsp_err}), 32'b011);
    chk("to_rdata_kept", 32'(rsp_rdata), 32'hA5);
    chk("to_psel_drop", 32'({psel, penable}), 32'd0);
    stuck = 1'b0;
    step();
    chk("to_psel_after", 32'(psel), 32'd0);

    // pready rises exactly when the count reaches TIMEOUT: normal completion
    wait_cfg = 8'd4;
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h06;
    step();
    req_valid = 2'b00;
    for (int c = 2; c <= 6; c++) step();
    step();
    chk("to_edge_done", 32'({req_done, rsp_err}), 32'b010);
    chk("to_edge_rdata", 32'(rsp_rdata), 32'h22);
    wait_cfg = 8'd0;
    step();
`endif

    // reset during ACCESS, then reissue
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h07; req_wdata = 16'h003C;
    step();
    req_valid = 2'b00;
    step();
    preset = 1'b1;
    step();
    chk("mr_outputs", 32'({psel, penable, pwrite, req_ack, req_done, rsp_err}), 32'd0);
    chk("mr_data", 32'({paddr, pwdata, rsp_rdata}), 32'd0);
    chk("mr_state", 32'(dut.state_r), 32'd0);
    preset = 1'b0;
    req_valid = 2'b01; req_wdata = 16'h005A;
    step();
    chk("mr_reissue_ack", 32'(req_ack), 32'd1);
    req_valid = 2'b00;
    step(); step();
    chk("mr_reissue_done", 32'({req_done, rsp_err}), 32'b010);
    chk("mr_mem7", 32'(mem[7]), 32'h5A);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares one APB slave between two local command sources. Each accepted command becomes a standard APB transfer: setup phase, then access phase extended by the slave's `pready` wait states. Arbitration is round-robin. An optional watchdog aborts transfers whose slave never returns `pready`. The block drives the slave's `psel`/`penable`/`paddr`/`pwdata`/`pwrite` and sits directly above the wait-state-capable APB slave.

## Interface
- `ADDR_W`, 4, APB address width
- `DATA_W`, 8, APB data width
- `TIMEOUT`, 15, access-phase cycles without `pready` before abort (1..255; used only with `APB_TIMEOUT_EN`)

- `pclk`  in  1  clock, rising edge
- `preset`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-requester command valid; held until that requester's `req_ack`
- `req_write`  in  2  per-requester direction, 1 = write
- `req_addr`  in  2×ADDR_W  packed addresses, requester 0 in LSBs
- `req_wdata`  in  2×DATA_W  packed write data, requester 0 in LSBs
- `req_ack`  out  2  one-cycle pulse: command accepted
- `req_done`  out  2  one-cycle pulse: transfer finished
- `rsp_rdata`  out  DATA_W  read data, valid with `req_done`
- `rsp_err`  out  1  timeout abort flag, valid with `req_done`
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB ready; low extends the access phase

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise grant one requester: if both are valid, grant the one named by the priority pointer `rr`; else grant the single valid one.
  - Latch that requester's write/addr/wdata into `paddr`/`pwrite`/`pwdata`.
  - Pulse its `req_ack` and go to SETUP.
  - After every grant, `rr` points to the requester not granted.
- SETUP: `psel`=1, `penable`=0, then unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - If `pready`=1 at the clock edge: register `prdata` into `rsp_rdata` (reads only; writes leave `rsp_rdata` unchanged), pulse the granted requester's `req_done` with `rsp_err`=0, deassert `psel`/`penable`, and go to IDLE.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS.
- No back-to-back transfers: every transfer passes through IDLE.
- A requester must hold its command valid until `req_ack`. While in IDLE, a `req_valid` arriving after an ack is treated as a new command.
- `rsp_err` and `rsp_rdata` hold their values until the next `req_done`.

## Timing
- All outputs are registered. Reset values: `psel`/`penable`/`pwrite`=0, `paddr`/`pwdata`/`rsp_rdata`=0, `req_ack`/`req_done`=0, `rsp_err`=0, state=IDLE, `rr`=0 (requester 0 favoured).
- `req_valid` first sampled at edge N:
  - `req_ack` and SETUP in cycle N+1.
  - ACCESS in cycle N+2.
  - With k wait states (pready low for k cycles), `req_done` in cycle N+3+k, state IDLE.
- Minimum transfer: 3 cycles. Next grant is no earlier than the edge ending the `req_done` cycle.
- Reset mid-transfer: the next edge forces all reset values. No `req_done` is issued for the aborted command; the requester must reissue it.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT` with `pready` still 0, the next edge pulses `req_done` with `rsp_err`=1, leaves `rsp_rdata` unchanged, drops `psel`/`penable`, and returns to IDLE.
  - If `pready`=1 in the same cycle the count reaches `TIMEOUT`, the transfer completes normally with `rsp_err`=0.
- `APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely; `rsp_err` is constant 0.

## Test plan
- Req0 writes 8'hA5 to addr 3, zero wait: `req_ack[0]` at N+1, `psel`=1/`penable`=0 at N+1, `penable`=1 at N+2, `req_done[0]` at N+3; slave mem[3]=A5.
- Req1 reads addr 3 with the slave holding `pready` low 2 cycles: `req_done[1]` at N+5, `rsp_rdata`=8'hA5, `rsp_err`=0, `paddr` stable at 3 throughout.
- Both requesters valid continuously, 4 transfers: grant order 0,1,0,1; each `req_ack` matches its grant; `rr` alternates.
- With `APB_TIMEOUT_EN` and `TIMEOUT`=4, `pready` stuck low: `req_done` with `rsp_err`=1 at N+7; `psel`=0 afterwards. Also, `pready` rising in the 4th low-count cycle gives `rsp_err`=0.
- `preset` asserted in cycle N+2 (ACCESS): next cycle all outputs 0, state IDLE, no `req_done`; a reissued command completes normally.
